// File: rtl/apu_len_pkg.sv
// apu_len_pkg: shared note-length table and index width for the length counter bank
package apu_len_pkg;
  localparam int LEN_IDX_W = 5;
  localparam logic [7:0] LENGTH_TABLE [0:31] = '{
    8'd10,  8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
    8'd160, 8'd8,   8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12,  8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24,  8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };
endpackage

// File: rtl/apu_length_counter_bank_if.sv
// apu_length_counter_bank_if: register/frame-counter strobes in, status/mute out
interface apu_length_counter_bank_if #(parameter int NUM_CH = 4);
  logic              ACLK_EN;
  logic [7:0]        DB;
  logic              W4015;
  logic [NUM_CH-1:0] W_LOAD;
  logic [NUM_CH-1:0] HALT;
  logic              nLFO2;
  logic [NUM_CH-1:0] LOCK;
  logic [NUM_CH-1:0] STATUS;
  logic [NUM_CH-1:0] NOCH;
  modport master (output ACLK_EN, DB, W4015, W_LOAD, HALT, nLFO2, LOCK, input STATUS, NOCH);
  modport slave  (input ACLK_EN, DB, W4015, W_LOAD, HALT, nLFO2, LOCK, output STATUS, NOCH);
endinterface

// File: rtl/apu_length_counter_ch.sv
// apu_length_counter_ch: one length counter with enable flop and load/decrement priority
module apu_length_counter_ch #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             n_RES,
  input  logic             tick,
  input  logic             w4015,
  input  logic             en_bit,
  input  logic             w_load,
  input  logic             halt,
  input  logic             lock,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);
  logic             en, en_nxt, dec;
  logic [CNT_W-1:0] cnt_nxt;
  // dec already implies cnt != 0, so giving it precedence over load realises the collision rule
  always_comb begin
    en_nxt  = w4015 ? en_bit : en;
    dec     = tick & ~halt & ~lock & (cnt != '0);
    cnt_nxt = !en_nxt ? '0 : dec ? cnt - CNT_W'(1) : w_load ? load_val : cnt;
  end
  always_ff @(posedge CLK or negedge n_RES)
    if (!n_RES) begin
      en  <= 1'b0;
      cnt <= '0;
    end else begin
      en  <= en_nxt;
      cnt <= cnt_nxt;
    end
endmodule

// File: rtl/apu_length_counter_bank.sv
// apu_length_counter_bank: NUM_CH independent note-length counters sharing one length table
module apu_length_counter_bank
  import apu_len_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input logic                      CLK,
  input logic                      n_RES,
  apu_length_counter_bank_if.slave bus
);
  logic [7:0]                   raw;
  logic [CNT_W-1:0]             load_val;
  logic                         tick;
  logic [NUM_CH-1:0]            status;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  // narrow builds clamp long table entries to the largest representable count
  always_comb begin
    raw      = LENGTH_TABLE[bus.DB[7 -: LEN_IDX_W]];
    load_val = (32'(raw) > 32'((64'd1 << CNT_W) - 64'd1)) ? '1 : CNT_W'(raw);
    tick     = bus.ACLK_EN & ~bus.nLFO2;
    for (int i = 0; i < NUM_CH; i++) status[i] = |cnt[i];
  end
  assign bus.STATUS = status;
  assign bus.NOCH   = ~status;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    apu_length_counter_ch #(.CNT_W(CNT_W)) u_ch (
      .CLK      (CLK),
      .n_RES    (n_RES),
      .tick     (tick),
      .w4015    (bus.W4015),
      .en_bit   (bus.DB[c]),
      .w_load   (bus.W_LOAD[c]),
      .halt     (bus.HALT[c]),
      .lock     (bus.LOCK[c]),
      .load_val (load_val),
      .cnt      (cnt[c])
    );
  end
endmodule

// File: doc/apu_length_counter_bank.md
Name: apu_length_counter_bank

Overview:
Parametrised bank of NUM_CH note-length counters, generalising the fixed four-channel length counter block of the APU.
- Each channel loads an 8-bit count from the shared 32-entry length table on its register-4 write (W4003-style strobe).
- Each channel decrements on half-frame strobes (nLFO2) and reports "counter is zero", which mutes the channel.
- New behaviour: per-channel debug LOCK freeze, synchronous parallel status readback, and a defined reload-versus-clock collision rule.
- Sits between the register decoder, frame counter and sound channels.

Parameters:
NUM_CH, 4, number of independent length counters (1..8)
CNT_W, 8, counter width; table values above 2^CNT_W-1 saturate to all-ones

Ports:
CLK  in  1  APU core clock; all state updates on rising edge
n_RES  in  1  asynchronous active-low reset
ACLK_EN  in  1  one-cycle qualifier marking the APU (ACLK) cycle; counter decrement only when high
DB  in  8  data bus
W4015  in  1  one-cycle strobe: DB[NUM_CH-1:0] written to enable register
W_LOAD  in  NUM_CH  one-cycle per-channel length-load strobes; index = DB[7:3]
HALT  in  NUM_CH  per-channel halt flag (envelope-loop/control bit), level
nLFO2  in  1  active-low half-frame strobe from frame counter
LOCK  in  NUM_CH  debug freeze per channel, level
STATUS  out  NUM_CH  1 = counter non-zero (4015 read data)
NOCH  out  NUM_CH  1 = counter zero (channel muted); always ~STATUS

Behaviour:
Reset (n_RES low, asynchronous):
- All counters = 0.
- All enables = 0.
- STATUS = 0; NOCH = all ones.
- Takes effect immediately; no strobe is honoured while n_RES is low.

Enable:
- On W4015, en[i] <= DB[i].
- Clearing en[i] forces cnt[i] to 0 on the same edge, overriding load and decrement.
- A load on a disabled channel is ignored.
- W4015 setting en[i] together with W_LOAD[i] on the same edge: the load uses the new enable (load accepted).

Load:
- When W_LOAD[i] and the effective en[i] are both 1, cnt[i] <= LENGTH_TABLE[DB[7:3]], saturated to CNT_W.
- Load is independent of ACLK_EN.

Decrement:
- dec[i] = ACLK_EN & ~nLFO2 & ~HALT[i] & ~LOCK[i] & (cnt[i] != 0).
- On a decrement, cnt[i] <= cnt[i]-1.
- Never wraps below 0.

Collision:
- W_LOAD[i] and a decrement condition on the same edge:
  - if cnt[i] was non-zero, the decrement applies and the load is dropped;
  - if cnt[i] was 0, the load applies.
- HALT and LOCK are sampled as current level; a halt change takes effect on that same edge.

LOCK:
- Blocks decrement only.
- Loads and enable-clears still apply.

Priority per channel: reset > enable-clear > collision rule > load > decrement > hold.

Outputs:
- STATUS and NOCH are combinational from the registered counters.
- Latency is 1 CLK from a strobe edge to the output change.

Channels are fully independent; simultaneous strobes on several channels are all honoured.

Decomposition:
- Package apu_len_pkg holds:
  - LENGTH_TABLE[0:31] = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30;
  - LEN_IDX_W = 5.
- Sub-module apu_length_counter_ch holds one channel (counter, enable flop, priority logic).
- The bank generates NUM_CH instances plus shared table lookup.

Test Plan:
1. Reset, W4015 DB=0x0F, W_LOAD[0] DB=0x08 (idx1) -> cnt0=254, STATUS=0001, NOCH=1110 after 1 CLK.
2. Load ch1 idx0 (10), apply 10 half-frame strobes with ACLK_EN=1 -> STATUS[1] falls exactly after the 10th; an 11th strobe keeps cnt1=0 (no wrap).
3. cnt2=20, HALT[2]=1 or LOCK[2]=1 over 5 strobes -> cnt2 stays 20; release -> next strobe gives 19.
4. cnt0=5, W_LOAD[0] idx3 same edge as decrement -> cnt0=4; repeat with cnt0=0 -> cnt0=2.
5. cnt3=48, W4015 DB=0x07 -> cnt3=0 next edge, STATUS[3]=0; W_LOAD[3] while disabled -> stays 0.
6. Assert n_RES low asynchronously mid-count (between edges) with cnt1=160 -> STATUS=0 immediately; NUM_CH=8, CNT_W=6 build: idx1 load saturates to 63.
